// File: rtl/boolean_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// boolean_sweep_ctrl
//
// Exhaustively exercises a 3-input Boolean circuit. A sweep walks the input
// index idx = {A,B,C} from 0 to 7. For each index the inputs are held for
// SETTLE_CYCLES cycles, then F is sampled for one cycle and compared against
// the truth table latched from Expected when the sweep was accepted.
//
// Handshake: a sweep is accepted when Start is high and Abort is low while the
// block is idle. Busy is high for the whole sweep. Done pulses for exactly one
// cycle when a sweep completes, and Captured/FailMask/Pass are valid from that
// cycle on. They hold until the next accepted Start. An aborted sweep produces
// no Done pulse.
//
// Ports
//   Clock       in   rising-edge clock
//   Reset       in   synchronous, active-high reset
//   Start       in   request one sweep (honoured only in IDLE)
//   Abort       in   stop a sweep in progress; beats Start in IDLE
//   Expected    in   [7:0] expected truth table, bit index {A,B,C}
//   F           in   output of the circuit under test
//   A, B, C     out  inputs driven into the circuit under test
//   Busy        out  high in SETTLE and SAMPLE
//   Done        out  one-cycle completion pulse
//   Pass        out  last completed sweep had no mismatches
//   Captured    out  [7:0] sampled F per combination
//   FailMask    out  [7:0] Captured XOR latched Expected
//   dbg_state_o out  [1:0] current FSM state, for observation
// ---------------------------------------------------------------------------
module boolean_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Abort,
    input  logic [7:0] Expected,
    input  logic       F,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       Busy,
    output logic       Done,
    output logic       Pass,
    output logic [7:0] Captured,
    output logic [7:0] FailMask,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] WCNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic [7:0] exp_q, exp_d;
    logic [7:0] cap_q, cap_d;
    logic [7:0] fm_q, fm_d;
    logic       pass_q, pass_d;
    logic [2:0] abc_q, abc_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        exp_d   = exp_q;
        cap_d   = cap_q;
        fm_d    = fm_q;
        pass_d  = pass_q;

        unique case (state_q)
            IDLE: begin
                if (Start && !Abort) begin
                    exp_d   = Expected;
                    idx_d   = 3'd0;
                    wcnt_d  = 4'd0;
                    cap_d   = 8'h00;
                    fm_d    = 8'h00;
                    pass_d  = 1'b0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (Abort) begin
                    wcnt_d  = 4'd0;
                    pass_d  = 1'b0;
                    state_d = IDLE;
                end else if (wcnt_q == WCNT_LAST) begin
                    wcnt_d  = 4'd0;
                    state_d = SAMPLE;
                end else begin
                    wcnt_d  = wcnt_q + 4'd1;
                end
            end
            SAMPLE: begin
                // Abort wins over the sample update so the partial results
                // stay exactly as they were before this cycle.
                if (Abort) begin
                    pass_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cap_d[idx_q] = F;
                    fm_d[idx_q]  = F ^ exp_q[idx_q];
                    if (idx_q == 3'd7) begin
                        // Pass is evaluated on the mask that already includes
                        // the last sample, so it is valid alongside Done.
                        pass_d  = (fm_d == 8'h00);
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SETTLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered: derive them from the next state so they
        // line up with the state they describe.
        busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
        abc_d  = busy_d ? idx_d : 3'b000;
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            wcnt_q  <= 4'd0;
            exp_q   <= 8'h00;
            cap_q   <= 8'h00;
            fm_q    <= 8'h00;
            pass_q  <= 1'b0;
            abc_q   <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            exp_q   <= exp_d;
            cap_q   <= cap_d;
            fm_q    <= fm_d;
            pass_q  <= pass_d;
            abc_q   <= abc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign {A, B, C}   = abc_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Pass        = pass_q;
    assign Captured    = cap_q;
    assign FailMask    = fm_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_boolean_sweep_ctrl.sv
// Bench for boolean_sweep_ctrl with SETTLE_CYCLES = 2.
// Each completed sweep is described by {Captured, FailMask, Pass, latency}.
// Drivers push the hand-computed record when they start a sweep that should
// complete; the monitor pops one record per Done pulse and compares.
module tb_boolean_sweep_ctrl;

    localparam int W = 25;  // 8 captured + 8 mask + 1 pass + 8 latency

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Abort = 1'b0;
    logic [7:0] Expected = 8'h00;
    logic       F;
    logic       A, B, C, Busy, Done, Pass;
    logic [7:0] Captured, FailMask;
    logic [1:0] dbg_state;

    // 0: majority(A,B,C)  1: stuck at 1  2: stuck at 0
    logic [1:0] f_mode = 2'd0;
    assign F = (f_mode == 2'd0) ? ((A & B) | (A & C) | (B & C)) :
               (f_mode == 2'd1);

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    logic prev_done = 1'b0;
    logic [W-1:0] exp_q[$];

    boolean_sweep_ctrl #(.SETTLE_CYCLES(2)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort),
        .Expected(Expected), .F(F), .A(A), .B(B), .C(C), .Busy(Busy),
        .Done(Done), .Pass(Pass), .Captured(Captured), .FailMask(FailMask),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge Clock) begin
        if (!Reset) begin
            if (Done) begin
                check("done_one_cycle", 32'(prev_done), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [W-1:0] exp_rec;
                    logic [W-1:0] got_rec;
                    logic [7:0]   lat;
                    exp_rec = exp_q.pop_front();
                    lat     = 8'(cyc - start_cyc);
                    got_rec = {Captured, FailMask, Pass, lat};
                    check("sweep_result", 32'(got_rec), 32'(exp_rec));
                end
            end
            prev_done = Done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_sweep(input logic [7:0] exp_tt);
        @(negedge Clock);
        Expected  = exp_tt;
        Start     = 1'b1;
        start_cyc = cyc + 1;  // the upcoming edge accepts Start
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic expect_sweep(input logic [7:0] cap, input logic [7:0] fm, input logic pass);
        exp_q.push_back({cap, fm, pass, 8'd24});
    endtask

    task automatic wait_abc(input logic [2:0] target, input string name);
        int n;
        n = 0;
        while (!(Busy && ({A, B, C} == target)) && n < 40) begin
            @(negedge Clock);
            n++;
        end
        if (n >= 40) check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge Clock);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        @(negedge Clock);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {8'h0, Captured, FailMask, 2'b0, A, B, C, Busy, Done, Pass}, 32'd0);
        check({name, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset held for two cycles
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        check_all_zero("reset");
        Reset = 1'b0;
        @(negedge Clock);

        // Golden sweep: majority function, table E8
        f_mode = 2'd0;
        expect_sweep(8'hE8, 8'h00, 1'b1);
        start_sweep(8'hE8);
        wait_abc(3'b100, "reach_abc_100");
        check("abc100_f", 32'(F), 32'd0);
        check("abc100_busy", 32'(Busy), 32'd1);
        wait_drain("golden_drain");
        repeat (3) @(negedge Clock);
        check("hold_captured", 32'(Captured), 32'hE8);
        check("hold_pass", 32'(Pass), 32'd1);
        check("idle_abc", 32'({A, B, C}), 32'd0);

        // Stuck-at-1 fault against an all-zero table
        f_mode = 2'd1;
        expect_sweep(8'hFF, 8'hFF, 1'b0);
        start_sweep(8'h00);
        wait_drain("stuck_drain");

        // Single mismatching entry: majority vs E9 differs at index 0
        f_mode = 2'd0;
        expect_sweep(8'hE8, 8'h01, 1'b0);
        start_sweep(8'hE9);
        wait_drain("mismatch_drain");

        // Abort at idx 3 while settling; stuck-at-1 makes partials visible
        f_mode = 2'd1;
        start_sweep(8'h00);
        wait_abc(3'b011, "reach_abc_011");
        check("abort_in_settle", 32'(dbg_state), 32'd1);
        Abort = 1'b1;
        @(negedge Clock);
        Abort = 1'b0;
        check("abort_abc", 32'({A, B, C}), 32'd0);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_pass", 32'(Pass), 32'd0);
        check("abort_cap", 32'(Captured), 32'h07);
        check("abort_fm", 32'(FailMask), 32'h07);
        repeat (30) @(negedge Clock);  // monitor flags any stray Done
        check("abort_no_done_cap", 32'(Captured[7:3]), 32'd0);

        // Start pulses and Expected changes during a sweep are ignored
        f_mode = 2'd0;
        expect_sweep(8'hE8, 8'h00, 1'b1);
        start_sweep(8'hE8);
        repeat (4) @(negedge Clock);
        Start = 1'b1;
        Expected = 8'h00;
        @(negedge Clock);
        Start = 1'b0;
        repeat (7) @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        wait_drain("ignored_start_drain");

        // Start together with Abort in IDLE stays idle
        Start = 1'b1;
        Abort = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        Abort = 1'b0;
        check("start_abort_busy", 32'(Busy), 32'd0);
        check("start_abort_state", 32'(dbg_state), 32'd0);
        @(negedge Clock);
        check("start_abort_busy2", 32'(Busy), 32'd0);

        // Reset in the middle of a sweep, then a clean full sweep
        f_mode = 2'd0;
        start_sweep(8'hE8);
        wait_abc(3'b101, "reach_abc_101");
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check_all_zero("mid_reset");
        expect_sweep(8'hE8, 8'h00, 1'b1);
        start_sweep(8'hE8);
        wait_drain("post_reset_drain");

        repeat (3) @(negedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
